vga_scan_ctrl: RTL

Controller that sequences the X-Y scan counter for the VGA path. It generates the pixel-rate enable from the system clock, starts and stops scanning only on frame boundaries, and derives hsync, vsync, active-video and frame/line markers from the (x, y) position. It sits between the top-level run control and the pixel generator/VGA pins.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_scan_ctrl_xy.sv | 37 +++
 rtl/vga_scan_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan path.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } scan_state_t;

    localparam int DEF_WIDTH   = 800;
    localparam int DEF_HEIGHT  = 525;
    localparam int DEF_HACTIVE = 640;
    localparam int DEF_HFP     = 16;
    localparam int DEF_HSYNC   = 96;
    localparam int DEF_VACTIVE = 480;
    localparam int DEF_VFP     = 10;
    localparam int DEF_VSYNC   = 2;
    localparam int DEF_CLKDIV  = 4;

endpackage

// File: rtl/vga_scan_ctrl_xy.sv
// X-Y raster position counter; wraps x at WIDTH-1 and y at HEIGHT-1.
module scan_xy_counter #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 525,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic xlast;
    logic ylast;

    assign xlast = (x == XW'(WIDTH - 1));
    assign ylast = (y == YW'(HEIGHT - 1));
    assign last  = xlast && ylast;

    always_ff @(posedge clock) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (xlast) begin
                x <= '0;
                y <= ylast ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan sequencer: pixel-rate divider, frame-aligned run/stop FSM, sync decode.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int HACTIVE = DEF_HACTIVE,
    parameter int HFP     = DEF_HFP,
    parameter int HSYNC   = DEF_HSYNC,
    parameter int VACTIVE = DEF_VACTIVE,
    parameter int VFP     = DEF_VFP,
    parameter int VSYNC   = DEF_VSYNC,
    parameter int CLKDIV  = DEF_CLKDIV
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      run,
    output logic                      pixel_en,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      active,
    output logic                      frame_start,
    output logic                      line_start,
    output logic                      busy
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    if (HACTIVE + HFP + HSYNC > WIDTH) begin : g_bad_h
        $error("vga_scan_ctrl: horizontal timing exceeds WIDTH");
    end
    if (VACTIVE + VFP + VSYNC > HEIGHT) begin : g_bad_v
        $error("vga_scan_ctrl: vertical timing exceeds HEIGHT");
    end
    if (CLKDIV < 1) begin : g_bad_div
        $error("vga_scan_ctrl: CLKDIV must be >= 1");
    end

    scan_state_t   state;
    scan_state_t   state_n;
    logic [DW-1:0] div;
    logic          last;
    logic [CW-1:0] xw;
    logic [RW-1:0] yw;

    assign busy     = (state != IDLE);
    assign pixel_en = busy && (div == DW'(CLKDIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !busy || pixel_en) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    // A pending run request always wins over the frame-end stop.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (run) state_n = RUN;
            RUN:     if (!run) state_n = DRAIN;
            DRAIN: begin
                if (run) state_n = RUN;
                else if (pixel_en && last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    scan_xy_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_xy (
        .clock (clock),
        .reset (reset),
        .en    (pixel_en),
        .x     (x),
        .y     (y),
        .last  (last)
    );

    assign xw = CW'(x);
    assign yw = RW'(y);

    assign hsync = !(busy && xw >= CW'(HACTIVE + HFP)
                          && xw <  CW'(HACTIVE + HFP + HSYNC));
    assign vsync = !(busy && yw >= RW'(VACTIVE + VFP)
                          && yw <  RW'(VACTIVE + VFP + VSYNC));
    assign active      = busy && xw < CW'(HACTIVE) && yw < RW'(VACTIVE);
    assign line_start  = busy && (x == '0) && (div == '0);
    assign frame_start = line_start && (y == '0);

endmodule
